// File: rtl/uart_pkg.sv
// Shared definitions for the UART link (receiver and transmitter).
//   rx_state_t            receiver FSM encoding
//   DATA_BITS             payload bits per frame (8N1)
//   CLKS_PER_BIT_DEFAULT  clk cycles per bit: 50 MHz / 9600 baud
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset; both flops load RESET_VAL
//   d      in   asynchronous input
//   q      out  synchronised copy of d, two clk cycles late
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output and error pulses.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, asynchronous, idle high
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  byte available, held until accepted
//   rx_ready   in   consumer accepts (transfer on rx_valid & rx_ready)
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: byte completed while previous one pending
//   busy       out  FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | timing to the middle of the start bit, rejects glitches
// DATA  | sampling the 8 data bits mid-bit, LSB first
// STOP  | sampling the stop bit, then back to IDLE on the same edge
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t            state, state_next;
    logic                 rx_s, rx_s_d;
    logic                 start_edge, sample_pt;
    logic [CW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop_ok;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_s_d <= 1'b1;
        else        rx_s_d <= rx_s;
    end

    assign start_edge = rx_s_d & ~rx_s;

    // The counter was cleared in IDLE, so the half-bit compare is one short of H
    // and every later sample point is exactly one full bit after the previous.
    always_comb begin
        sample_pt = 1'b0;
        if (state == START) sample_pt = (baud_cnt == HALF_LAST);
        else                sample_pt = (baud_cnt == BIT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start_edge) state_next = START;
            START: if (sample_pt)  state_next = rx_s ? IDLE : DATA;
            DATA:  if (sample_pt && bit_cnt == LAST_BIT) state_next = STOP;
            STOP:  if (sample_pt)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == IDLE || sample_pt) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == DATA && sample_pt) begin
                bit_cnt   <= bit_cnt + 1'b1;
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // Stop-bit result is registered, so the output stage acts one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_ok   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            stop_ok   <= (state == STOP) && sample_pt && rx_s;
            frame_err <= (state == STOP) && sample_pt && !rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (stop_ok) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: observes outputs on the falling edge, away from the active edge.
    logic [7:0] xfer_q[$];
    int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, valid_cnt = 0, busy_cnt = 0;
    int last_rise = -1;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) xfer_q.push_back(rx_data);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid) valid_cnt++;
        if (busy) busy_cnt++;
        if (rx_valid && !valid_prev) last_rise = cyc;
        valid_prev = rx_valid;
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int idx);
        if (idx < xfer_q.size()) return xfer_q[idx];
        return 8'hxx;
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_xfers;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    int qb, fb, ob, vb, bb, c0;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[2] = '{8'h01, 1'b1, 1, 8'h01, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 8'h80, 0};
        vecs[4] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[5] = '{8'h40, 1'b0, 0, 8'h00, 1};
        vecs[6] = '{8'h55, 1'b1, 1, 8'h55, 0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        idle(5);

        // Frame 0xCA: latency 3 sync cycles + 153, single-cycle valid
        qb = xfer_q.size(); fb = ferr_cnt; ob = ovr_cnt; vb = valid_cnt;
        c0 = cyc;
        send_frame(8'hCA, 1'b1);
        idle(4);
        check("lat_rise", 32'(last_rise - c0), 32'd156);
        check("lat_valid_width", 32'(valid_cnt - vb), 32'd1);
        check("lat_xfers", 32'(xfer_q.size() - qb), 32'd1);
        check("lat_data", 32'(q_at(qb)), 32'hCA);
        check("lat_ferr", 32'(ferr_cnt - fb), 32'd0);
        check("lat_ovr", 32'(ovr_cnt - ob), 32'd0);

        // Table of single frames, consumer always ready
        for (int v = 0; v < 7; v++) begin
            qb = xfer_q.size(); fb = ferr_cnt; ob = ovr_cnt;
            send_frame(vecs[v].data, vecs[v].stop_bit);
            idle(4);
            check($sformatf("vec%0d_xfers", v), 32'(xfer_q.size() - qb), 32'(vecs[v].exp_xfers));
            if (vecs[v].exp_xfers > 0)
                check($sformatf("vec%0d_data", v), 32'(q_at(qb)), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - fb), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - ob), 32'd0);
            check($sformatf("vec%0d_valid_end", v), 32'(rx_valid), 32'd0);
        end

        // Back-to-back 0xB2, 0x00 with no idle gap
        qb = xfer_q.size(); fb = ferr_cnt; ob = ovr_cnt;
        send_frame(8'hB2, 1'b1);
        send_frame(8'h00, 1'b1);
        idle(4);
        check("b2b_xfers", 32'(xfer_q.size() - qb), 32'd2);
        check("b2b_first", 32'(q_at(qb)), 32'hB2);
        check("b2b_second", 32'(q_at(qb + 1)), 32'h00);
        check("b2b_errs", 32'((ferr_cnt - fb) + (ovr_cnt - ob)), 32'd0);

        // 4-cycle glitch: START for H cycles then back to IDLE
        qb = xfer_q.size(); vb = valid_cnt; bb = busy_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(30);
        check("glitch_busy_cycles", 32'(busy_cnt - bb), 32'd8);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_valid", 32'(valid_cnt - vb), 32'd0);
        check("glitch_xfers", 32'(xfer_q.size() - qb), 32'd0);

        // Overrun: 0xCA held, 0xB2 dropped
        rx_ready = 1'b0;
        qb = xfer_q.size(); fb = ferr_cnt; ob = ovr_cnt;
        send_frame(8'hCA, 1'b1);
        send_frame(8'hB2, 1'b1);
        idle(4);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data", 32'(rx_data), 32'hCA);
        check("ovr_pulse", 32'(ovr_cnt - ob), 32'd1);
        check("ovr_ferr", 32'(ferr_cnt - fb), 32'd0);
        check("ovr_no_xfer", 32'(xfer_q.size() - qb), 32'd0);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_valid_drop", 32'(rx_valid), 32'd0);
        check("ovr_accepted", 32'(q_at(qb)), 32'hCA);
        idle(4);

        // Reset during data bit 3 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst_async_outs", 32'({rx_data, rx_valid, frame_err, overrun, busy}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        qb = xfer_q.size(); fb = ferr_cnt;
        send_frame(8'h40, 1'b1);
        idle(4);
        check("post_rst_xfers", 32'(xfer_q.size() - qb), 32'd1);
        check("post_rst_data", 32'(q_at(qb)), 32'h40);
        check("post_rst_ferr", 32'(ferr_cnt - fb), 32'd0);

        check("never_both_errs", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
